mac_stream: RTL and testbench

- Pipelined, stream-driven multiply-accumulate processing element. Parametrised successor to the team's basic MAC cell.
- Accepts operand pairs under a valid/ready handshake. Computes a dot product terminated by in_last.
- Supports signed/unsigned mode and a saturating accumulator with overflow flag and term count. Emits each result under its own valid/ready handshake.
- Forwards registered operands for systolic chaining inside the matrix-multiply array.

---
 rtl/mac_pkg.sv | 21 ++
 rtl/mac_sat_add.sv | 51 +++++
 rtl/mac_stream.sv | 262 ++++++++++++++++++++++++++
 tb/tb_mac_stream.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared types and default parameter values for the streaming MAC processing
// element.
//   mac_mode_e : operand interpretation for one dot product (unsigned / signed)
//   pe_state_e : first-term tracking state of the PE
package mac_pkg;

   localparam int DEF_WIDTH     = 8;
   localparam int DEF_CNT_WIDTH = 16;
   localparam bit DEF_SATURATE  = 1'b1;

   typedef enum logic {
      MODE_UNSIGNED = 1'b0,
      MODE_SIGNED   = 1'b1
   } mac_mode_e;

   typedef enum logic {
      PE_IDLE  = 1'b0,
      PE_ACCUM = 1'b1
   } pe_state_e;

endpackage

// File: rtl/mac_sat_add.sv
// Combinational accumulate step with overflow detection and optional clamp.
// Ports:
//   acc_in   : current accumulator value, ACC_WIDTH bits
//   prod_ext : product already sign/zero-extended to ACC_WIDTH+1 bits
//   mode     : MODE_SIGNED interprets both operands as two's complement
//   sum      : new accumulator value (clamped when SATURATE=1, else wrapped)
//   ovf      : the true sum did not fit in ACC_WIDTH bits
module mac_sat_add
   import mac_pkg::*;
#(
   parameter int ACC_WIDTH = 32,
   parameter bit SATURATE  = 1'b1
) (
   input  logic [ACC_WIDTH-1:0] acc_in,
   input  logic [ACC_WIDTH:0]   prod_ext,
   input  mac_mode_e            mode,
   output logic [ACC_WIDTH-1:0] sum,
   output logic                 ovf
);

   logic [ACC_WIDTH:0] acc_ext;
   logic [ACC_WIDTH:0] raw_sum;

   // Add in ACC_WIDTH+1 bits so the true sum is always representable. In
   // unsigned mode the extra bit is a carry out; in signed mode a mismatch
   // between the top two bits means the result left the signed range, and the
   // top bit then tells us which end to clamp to.
   always_comb begin
      if (mode == MODE_SIGNED) begin
         acc_ext = {acc_in[ACC_WIDTH-1], acc_in};
      end else begin
         acc_ext = {1'b0, acc_in};
      end
      raw_sum = acc_ext + prod_ext;
      if (mode == MODE_SIGNED) begin
         ovf = raw_sum[ACC_WIDTH] ^ raw_sum[ACC_WIDTH-1];
      end else begin
         ovf = raw_sum[ACC_WIDTH];
      end
      sum = raw_sum[ACC_WIDTH-1:0];
      if (ovf && SATURATE) begin
         if (mode == MODE_SIGNED) begin
            sum = raw_sum[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                     : {1'b0, {(ACC_WIDTH-1){1'b1}}};
         end else begin
            sum = '1;
         end
      end
   end

endmodule

// File: rtl/mac_stream.sv
// Pipelined stream multiply-accumulate processing element.
// Operand beats arrive under in_valid/in_ready; in_last terminates a dot
// product whose result leaves under res_valid/res_ready. Registered operands
// are forwarded on a_out/b_out/fwd_valid for systolic chaining.
// Ports:
//   clk, reset            : clock, asynchronous active-high reset
//   in_valid/in_ready     : operand beat handshake
//   a_in, b_in            : operands, WIDTH bits
//   in_last               : beat is the final term of the dot product
//   signed_en             : signed mode, honoured on the first beat only
//   a_out, b_out          : stage-1 operands for the neighbouring PE
//   fwd_valid             : a_out/b_out hold a beat accepted this step
//   res_valid/res_ready   : result handshake
//   res_data              : dot-product result, ACC_WIDTH bits
//   res_ovf               : overflow occurred anywhere in the dot product
//   res_count             : number of terms, saturating at all-ones
module mac_stream
   import mac_pkg::*;
#(
   parameter int WIDTH     = DEF_WIDTH,
   parameter int ACC_WIDTH = 4 * WIDTH,
   parameter int CNT_WIDTH = DEF_CNT_WIDTH,
   parameter bit SATURATE  = DEF_SATURATE
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     a_in,
   input  logic [WIDTH-1:0]     b_in,
   input  logic                 in_last,
   input  logic                 signed_en,
   output logic [WIDTH-1:0]     a_out,
   output logic [WIDTH-1:0]     b_out,
   output logic                 fwd_valid,
   output logic                 res_valid,
   input  logic                 res_ready,
   output logic [ACC_WIDTH-1:0] res_data,
   output logic                 res_ovf,
   output logic [CNT_WIDTH-1:0] res_count
);

   localparam int PW = 2 * WIDTH;

   pe_state_e            state_q, state_d;
   mac_mode_e            mode_q, mode_d;

   logic                 s1_valid_q, s1_valid_d;
   logic [WIDTH-1:0]     s1_a_q, s1_a_d;
   logic [WIDTH-1:0]     s1_b_q, s1_b_d;
   logic                 s1_last_q, s1_last_d;
   logic                 s1_first_q, s1_first_d;
   mac_mode_e            s1_mode_q, s1_mode_d;

   logic                 s2_valid_q, s2_valid_d;
   logic [PW-1:0]        s2_prod_q, s2_prod_d;
   logic                 s2_last_q, s2_last_d;
   logic                 s2_first_q, s2_first_d;
   mac_mode_e            s2_mode_q, s2_mode_d;

   logic [ACC_WIDTH-1:0] acc_q, acc_d;
   logic                 acc_ovf_q, acc_ovf_d;
   logic [CNT_WIDTH-1:0] acc_cnt_q, acc_cnt_d;

   logic                 res_valid_q, res_valid_d;
   logic [ACC_WIDTH-1:0] res_data_q, res_data_d;
   logic                 res_ovf_q, res_ovf_d;
   logic [CNT_WIDTH-1:0] res_count_q, res_count_d;

   logic                 stall;
   logic                 accept;
   logic                 beat_first;
   mac_mode_e            beat_mode;
   logic [PW-1:0]        op_a_ext, op_b_ext, product;
   logic [ACC_WIDTH:0]   prod_ext;
   logic [ACC_WIDTH-1:0] acc_base, add_sum;
   logic                 add_ovf;
   logic [CNT_WIDTH-1:0] cnt_base, cnt_next;

   // The only source of backpressure is an unconsumed result; everything
   // upstream freezes with it so no beat in flight is ever lost.
   always_comb begin
      stall    = res_valid_q & ~res_ready;
      in_ready = ~stall;
      accept   = in_valid & ~stall;
   end

   // First-term tracking. The beat seen in PE_IDLE opens a dot product and
   // fixes its mode; later beats inherit the latched mode so signed_en is
   // free to change mid-stream. A last beat always closes the dot product.
   always_comb begin
      state_d    = state_q;
      mode_d     = mode_q;
      beat_first = (state_q == PE_IDLE);
      if (beat_first) begin
         beat_mode = signed_en ? MODE_SIGNED : MODE_UNSIGNED;
      end else begin
         beat_mode = mode_q;
      end
      if (accept) begin
         mode_d  = beat_mode;
         state_d = in_last ? PE_IDLE : PE_ACCUM;
      end
   end

   // Multiply in 2*WIDTH bits on operands pre-extended to 2*WIDTH; the low
   // half of that product is the exact signed or unsigned result.
   always_comb begin
      if (s1_mode_q == MODE_SIGNED) begin
         op_a_ext = {{WIDTH{s1_a_q[WIDTH-1]}}, s1_a_q};
         op_b_ext = {{WIDTH{s1_b_q[WIDTH-1]}}, s1_b_q};
      end else begin
         op_a_ext = {{WIDTH{1'b0}}, s1_a_q};
         op_b_ext = {{WIDTH{1'b0}}, s1_b_q};
      end
      product = op_a_ext * op_b_ext;
   end

   // Accumulate operands for stage 3. A first term starts from a clean slate
   // so no state from an earlier dot product leaks in, even if the
   // accumulator was not yet zeroed by a last beat.
   always_comb begin
      if (s2_mode_q == MODE_SIGNED) begin
         prod_ext = {{(ACC_WIDTH + 1 - PW){s2_prod_q[PW-1]}}, s2_prod_q};
      end else begin
         prod_ext = {{(ACC_WIDTH + 1 - PW){1'b0}}, s2_prod_q};
      end
      acc_base = s2_first_q ? '0 : acc_q;
      cnt_base = s2_first_q ? '0 : acc_cnt_q;
      if (&cnt_base) begin
         cnt_next = cnt_base;
      end else begin
         cnt_next = cnt_base + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end
   end

   mac_sat_add #(
      .ACC_WIDTH (ACC_WIDTH),
      .SATURATE  (SATURATE)
   ) u_sat_add (
      .acc_in   (acc_base),
      .prod_ext (prod_ext),
      .mode     (s2_mode_q),
      .sum      (add_sum),
      .ovf      (add_ovf)
   );

   // Pipeline advance. Every register holds while stalled. A last beat in
   // stage 3 hands its totals to the result register and zeroes the
   // accumulator in the same step, so a following dot product can start on
   // the very next beat.
   always_comb begin
      s1_valid_d  = s1_valid_q;
      s1_a_d      = s1_a_q;
      s1_b_d      = s1_b_q;
      s1_last_d   = s1_last_q;
      s1_first_d  = s1_first_q;
      s1_mode_d   = s1_mode_q;
      s2_valid_d  = s2_valid_q;
      s2_prod_d   = s2_prod_q;
      s2_last_d   = s2_last_q;
      s2_first_d  = s2_first_q;
      s2_mode_d   = s2_mode_q;
      acc_d       = acc_q;
      acc_ovf_d   = acc_ovf_q;
      acc_cnt_d   = acc_cnt_q;
      res_valid_d = res_valid_q;
      res_data_d  = res_data_q;
      res_ovf_d   = res_ovf_q;
      res_count_d = res_count_q;
      if (!stall) begin
         s1_valid_d = accept;
         if (accept) begin
            s1_a_d     = a_in;
            s1_b_d     = b_in;
            s1_last_d  = in_last;
            s1_first_d = beat_first;
            s1_mode_d  = beat_mode;
         end
         s2_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            s2_prod_d  = product;
            s2_last_d  = s1_last_q;
            s2_first_d = s1_first_q;
            s2_mode_d  = s1_mode_q;
         end
         res_valid_d = s2_valid_q & s2_last_q;
         if (s2_valid_q) begin
            if (s2_last_q) begin
               res_data_d  = add_sum;
               res_ovf_d   = add_ovf | (~s2_first_q & acc_ovf_q);
               res_count_d = cnt_next;
               acc_d       = '0;
               acc_ovf_d   = 1'b0;
               acc_cnt_d   = '0;
            end else begin
               acc_d       = add_sum;
               acc_ovf_d   = add_ovf | (~s2_first_q & acc_ovf_q);
               acc_cnt_d   = cnt_next;
            end
         end
      end
   end

   // State registers; reset drops every partial dot product on the floor.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= PE_IDLE;
         mode_q      <= MODE_UNSIGNED;
         s1_valid_q  <= 1'b0;
         s1_a_q      <= '0;
         s1_b_q      <= '0;
         s1_last_q   <= 1'b0;
         s1_first_q  <= 1'b0;
         s1_mode_q   <= MODE_UNSIGNED;
         s2_valid_q  <= 1'b0;
         s2_prod_q   <= '0;
         s2_last_q   <= 1'b0;
         s2_first_q  <= 1'b0;
         s2_mode_q   <= MODE_UNSIGNED;
         acc_q       <= '0;
         acc_ovf_q   <= 1'b0;
         acc_cnt_q   <= '0;
         res_valid_q <= 1'b0;
         res_data_q  <= '0;
         res_ovf_q   <= 1'b0;
         res_count_q <= '0;
      end else begin
         state_q     <= state_d;
         mode_q      <= mode_d;
         s1_valid_q  <= s1_valid_d;
         s1_a_q      <= s1_a_d;
         s1_b_q      <= s1_b_d;
         s1_last_q   <= s1_last_d;
         s1_first_q  <= s1_first_d;
         s1_mode_q   <= s1_mode_d;
         s2_valid_q  <= s2_valid_d;
         s2_prod_q   <= s2_prod_d;
         s2_last_q   <= s2_last_d;
         s2_first_q  <= s2_first_d;
         s2_mode_q   <= s2_mode_d;
         acc_q       <= acc_d;
         acc_ovf_q   <= acc_ovf_d;
         acc_cnt_q   <= acc_cnt_d;
         res_valid_q <= res_valid_d;
         res_data_q  <= res_data_d;
         res_ovf_q   <= res_ovf_d;
         res_count_q <= res_count_d;
      end
   end

   always_comb begin
      a_out     = s1_a_q;
      b_out     = s1_b_q;
      fwd_valid = s1_valid_q;
      res_valid = res_valid_q;
      res_data  = res_data_q;
      res_ovf   = res_ovf_q;
      res_count = res_count_q;
   end

endmodule

// File: tb/tb_mac_stream.sv
// Testbench for mac_stream. Two instances share all inputs: one with the
// default 32-bit accumulator and one with a 16-bit saturating accumulator.
// A dot-product-level reference model produces the expected results.
module tb_mac_stream;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic [7:0]  a_in, b_in;
   logic        in_last;
   logic        signed_en;
   logic        res_ready;

   logic        in_ready_a, fwd_valid_a, res_valid_a, res_ovf_a;
   logic [7:0]  a_out_a, b_out_a;
   logic [31:0] res_data_a;
   logic [15:0] res_count_a;

   logic        in_ready_b, fwd_valid_b, res_valid_b, res_ovf_b;
   logic [7:0]  a_out_b, b_out_b;
   logic [15:0] res_data_b;
   logic [15:0] res_count_b;

   typedef struct {
      logic [31:0] data;
      logic        ovf;
      logic [15:0] cnt;
   } res_t;

   res_t   qA[$];
   res_t   qB[$];
   int     nAssert = 0;
   int     nFail   = 0;
   int     readyPct = 100;
   int     waits;

   longint mdlAcc [2];
   bit     mdlOvf [2];
   int     mdlCnt [2];
   bit     mdlMode[2];
   bit     inDot  [2];
   int     accW   [2] = '{32, 16};

   logic       fwdExpValid = 1'b0;
   logic [7:0] fwdExpA = '0;
   logic [7:0] fwdExpB = '0;

   mac_stream dutA (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_a),
      .a_in(a_in), .b_in(b_in), .in_last(in_last), .signed_en(signed_en),
      .a_out(a_out_a), .b_out(b_out_a), .fwd_valid(fwd_valid_a),
      .res_valid(res_valid_a), .res_ready(res_ready), .res_data(res_data_a),
      .res_ovf(res_ovf_a), .res_count(res_count_a)
   );

   mac_stream #(.ACC_WIDTH(16)) dutB (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_b),
      .a_in(a_in), .b_in(b_in), .in_last(in_last), .signed_en(signed_en),
      .a_out(a_out_b), .b_out(b_out_b), .fwd_valid(fwd_valid_b),
      .res_valid(res_valid_b), .res_ready(res_ready), .res_data(res_data_b),
      .res_ovf(res_ovf_b), .res_count(res_count_b)
   );

   // Free-running clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard stop in case something wedges
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nAssert++;
      assert (obs === exp) else begin
         nFail++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic pickReady();
      if (readyPct >= 100) return 1'b1;
      if (readyPct <= 0) return 1'b0;
      return ($urandom_range(0, 99) < readyPct);
   endfunction

   // Dot-product reference: plain integer arithmetic, clamped after each term
   task automatic modelBeat(input logic [7:0] a, input logic [7:0] b, input logic last, input logic sgn);
      longint av, bv, hi, lo, t;
      res_t   r;
      for (int i = 0; i < 2; i++) begin
         if (!inDot[i]) begin
            mdlMode[i] = sgn;
            mdlAcc[i]  = 0;
            mdlOvf[i]  = 0;
            mdlCnt[i]  = 0;
            inDot[i]   = 1;
         end
         av = mdlMode[i] ? longint'($signed(a)) : longint'(a);
         bv = mdlMode[i] ? longint'($signed(b)) : longint'(b);
         if (mdlMode[i]) begin
            hi = (longint'(1) <<< (accW[i] - 1)) - 1;
            lo = -(longint'(1) <<< (accW[i] - 1));
         end else begin
            hi = (longint'(1) <<< accW[i]) - 1;
            lo = 0;
         end
         t = mdlAcc[i] + av * bv;
         if (t > hi) begin
            t = hi;
            mdlOvf[i] = 1;
         end else if (t < lo) begin
            t = lo;
            mdlOvf[i] = 1;
         end
         mdlAcc[i] = t;
         if (mdlCnt[i] < 65535) mdlCnt[i]++;
         if (last) begin
            r.ovf = mdlOvf[i];
            r.cnt = 16'(mdlCnt[i]);
            if (i == 0) begin
               r.data = t[31:0];
               qA.push_back(r);
            end else begin
               r.data = {16'h0, t[15:0]};
               qB.push_back(r);
            end
            inDot[i] = 0;
         end
      end
   endtask

   // Present one beat, retrying each cycle until the DUT takes it
   task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic last,
                                input logic sgn, output int nWait);
      bit accepted;
      accepted = 0;
      nWait = 0;
      while (!accepted && nWait <= 200) begin
         @(negedge clk);
         in_valid  = 1'b1;
         a_in      = a;
         b_in      = b;
         in_last   = last;
         signed_en = sgn;
         res_ready = pickReady();
         #1;
         if (in_ready_a) begin
            accepted = 1;
            modelBeat(a, b, last, sgn);
         end else begin
            nWait++;
         end
      end
      if (!accepted) checkOutput("accept_timeout", 64'(nWait), 64'd0);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic idleCycle();
      @(negedge clk);
      in_valid  = 1'b0;
      res_ready = pickReady();
      #1;
   endtask

   task automatic doReset();
      @(negedge clk);
      reset    = 1'b1;
      in_valid = 1'b0;
      qA.delete();
      qB.delete();
      for (int i = 0; i < 2; i++) inDot[i] = 0;
      fwdExpValid = 1'b0;
      #1;
      checkOutput("rst_res_valid_a", 64'(res_valid_a), 64'd0);
      checkOutput("rst_res_data_a",  64'(res_data_a),  64'd0);
      checkOutput("rst_res_ovf_a",   64'(res_ovf_a),   64'd0);
      checkOutput("rst_res_count_a", 64'(res_count_a), 64'd0);
      checkOutput("rst_fwd_valid_a", 64'(fwd_valid_a), 64'd0);
      checkOutput("rst_a_out_a",     64'(a_out_a),     64'd0);
      checkOutput("rst_b_out_a",     64'(b_out_a),     64'd0);
      checkOutput("rst_res_valid_b", 64'(res_valid_b), 64'd0);
      checkOutput("rst_res_data_b",  64'(res_data_b),  64'd0);
      checkOutput("rst_res_ovf_b",   64'(res_ovf_b),   64'd0);
      checkOutput("rst_res_count_b", 64'(res_count_b), 64'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic drain();
      readyPct = 100;
      for (int i = 0; i < 100 && (qA.size() != 0 || qB.size() != 0); i++) idleCycle();
      checkOutput("drain_a", 64'(qA.size()), 64'd0);
      checkOutput("drain_b", 64'(qB.size()), 64'd0);
   endtask

   // Cycle monitor: checks the state left by the last edge, then accounts for
   // what the coming edge will do (forwarded beat, consumed result).
   always @(negedge clk) begin
      #2;
      if (!reset) begin
         checkOutput("fwd_valid_a", 64'(fwd_valid_a), 64'(fwdExpValid));
         checkOutput("fwd_valid_b", 64'(fwd_valid_b), 64'(fwdExpValid));
         if (fwdExpValid) begin
            checkOutput("a_out", 64'(a_out_a), 64'(fwdExpA));
            checkOutput("b_out", 64'(b_out_a), 64'(fwdExpB));
         end
         if (res_valid_a) begin
            if (qA.size() == 0) begin
               checkOutput("res_unexpected_a", 64'(res_valid_a), 64'd0);
            end else begin
               checkOutput("res_data_a",  64'(res_data_a),  64'(qA[0].data));
               checkOutput("res_ovf_a",   64'(res_ovf_a),   64'(qA[0].ovf));
               checkOutput("res_count_a", 64'(res_count_a), 64'(qA[0].cnt));
            end
         end
         if (res_valid_b) begin
            if (qB.size() == 0) begin
               checkOutput("res_unexpected_b", 64'(res_valid_b), 64'd0);
            end else begin
               checkOutput("res_data_b",  64'(res_data_b),  64'(qB[0].data));
               checkOutput("res_ovf_b",   64'(res_ovf_b),   64'(qB[0].ovf));
               checkOutput("res_count_b", 64'(res_count_b), 64'(qB[0].cnt));
            end
         end
         if (in_ready_a) begin
            fwdExpValid = in_valid;
            if (in_valid) begin
               fwdExpA = a_in;
               fwdExpB = b_in;
            end
         end
         if (res_valid_a && res_ready && qA.size() != 0) void'(qA.pop_front());
         if (res_valid_b && res_ready && qB.size() != 0) void'(qB.pop_front());
      end
   end

   initial begin
      reset     = 1'b1;
      in_valid  = 1'b0;
      a_in      = '0;
      b_in      = '0;
      in_last   = 1'b0;
      signed_en = 1'b0;
      res_ready = 1'b1;
      doReset();

      // Unsigned 4-term dot product with latency check
      $display("[TB] unsigned dot product");
      applyStimulus(8'd1, 8'd2, 1'b0, 1'b0, waits);
      applyStimulus(8'd3, 8'd4, 1'b0, 1'b0, waits);
      applyStimulus(8'd5, 8'd6, 1'b0, 1'b0, waits);
      applyStimulus(8'd7, 8'd8, 1'b1, 1'b0, waits);
      idleCycle();
      checkOutput("lat_e0", 64'(res_valid_a), 64'd0);
      idleCycle();
      checkOutput("lat_e1", 64'(res_valid_a), 64'd0);
      idleCycle();
      checkOutput("lat_e2", 64'(res_valid_a), 64'd1);
      checkOutput("dot4_data", 64'(res_data_a), 64'd100);
      checkOutput("dot4_count", 64'(res_count_a), 64'd4);
      drain();

      // Signed, second beat's signed_en ignored
      $display("[TB] signed dot product");
      applyStimulus(8'hFD, 8'd5, 1'b0, 1'b1, waits);
      applyStimulus(8'd7, 8'hFE, 1'b1, 1'b0, waits);
      drain();

      // Saturation cases (visible on the 16-bit instance)
      $display("[TB] saturation");
      applyStimulus(8'd255, 8'd255, 1'b0, 1'b0, waits);
      applyStimulus(8'd255, 8'd255, 1'b1, 1'b0, waits);
      applyStimulus(8'h80, 8'h80, 1'b0, 1'b1, waits);
      applyStimulus(8'h80, 8'h80, 1'b1, 1'b1, waits);
      applyStimulus(8'd1, 8'd1, 1'b1, 1'b0, waits);
      drain();

      // Backpressure while a second dot product streams
      $display("[TB] backpressure");
      readyPct = 0;
      applyStimulus(8'd1, 8'd1, 1'b1, 1'b0, waits);
      applyStimulus(8'd2, 8'd2, 1'b0, 1'b0, waits);
      applyStimulus(8'd3, 8'd3, 1'b0, 1'b0, waits);
      for (int i = 0; i < 5; i++) begin
         idleCycle();
         checkOutput("bp_in_ready", 64'(in_ready_a), 64'd0);
         checkOutput("bp_hold_data", 64'(res_data_a), 64'd1);
      end
      readyPct = 100;
      applyStimulus(8'd4, 8'd4, 1'b1, 1'b0, waits);
      drain();

      // Reset in the middle of a dot product
      $display("[TB] reset mid dot product");
      applyStimulus(8'd9, 8'd9, 1'b0, 1'b0, waits);
      applyStimulus(8'd8, 8'd8, 1'b0, 1'b0, waits);
      doReset();
      applyStimulus(8'd3, 8'd3, 1'b1, 1'b0, waits);
      drain();

      // Back-to-back single-beat dot products at full rate
      $display("[TB] back-to-back single beats");
      for (int k = 1; k <= 8; k++) begin
         applyStimulus(8'(k), 8'(k), 1'b1, 1'b0, waits);
         checkOutput("b2b_wait", 64'(waits), 64'd0);
      end
      drain();

      // Randomized dot products with random backpressure
      $display("[TB] random phase");
      readyPct = 60;
      for (int n = 0; n < 40; n++) begin
         int len;
         len = $urandom_range(1, 6);
         for (int j = 0; j < len; j++) begin
            applyStimulus(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                          (j == len - 1), 1'($urandom_range(0, 1)), waits);
            if ($urandom_range(0, 3) == 0) idleCycle();
         end
      end
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
      $finish;
   end

endmodule
